fsb_trace_replay_engine: RTL and testbench
==========================================

Name: fsb_trace_replay_engine

Overview:
- ROM-driven trace player that sequences valid/yumi and ready/valid transactions from a trace of {4-bit opcode, payload} entries.
- Drives one channel of a memory/network model, e.g. one DRAM channel request port (payload = {write_not_read, ch_addr}).
- Reads an external combinational ROM through rom_addr_o/rom_data_i.
- Sends payloads, checks received data, waits, and signals completion and mismatch errors.

Parameters:
- ring_width_p, 80: payload width; also the width of data_o and data_i.
- rom_addr_width_p, 20: ROM address width.
- counter_width_p, 16: cycle-counter width; must be ≤ ring_width_p.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  enable; when 0 the engine freezes.
- v_i  in  1  receive-side valid.
- data_i  in  ring_width_p  receive-side data, compared against the payload.
- ready_and_o  out  1  receive-side ready.
- v_o  out  1  send-side valid.
- data_o  out  ring_width_p  send-side data (current payload).
- yumi_i  in  1  send-side consume; legal only when v_o=1.
- rom_addr_o  out  rom_addr_width_p  current trace address.
- rom_data_i  in  ring_width_p+4  ROM word, combinational from rom_addr_o.
- done_o  out  1  trace finished (sticky).
- error_o  out  1  mismatch or illegal opcode seen (sticky).

Behaviour:
- Decode: op = rom_data_i[ring_width_p+3:ring_width_p]; payload = rom_data_i[ring_width_p-1:0].
- State: addr_r, cnt_r (counter_width_p bits), done_r, error_r.
- Reset: async clear of all state. During and after reset, until the first instruction executes: rom_addr_o=0, v_o=0, ready_and_o=0, done_o=0, error_o=0.
- active = en_i & ~done_r. When active=0: v_o=0, ready_and_o=0, no state change.
- data_o = payload at all times; it is only meaningful when v_o=1.
- "Advance" means addr_r <= addr_r+1, wrapping from 2^rom_addr_width_p-1 to 0.
- Opcodes, evaluated each cycle while active:
  - 0 WAIT: advance next edge; one cycle per instruction.
  - 1 SEND: v_o=1. Advance on the edge where yumi_i=1; otherwise hold and keep v_o and data_o stable.
  - 2 RECV: ready_and_o=1. On the edge where v_i=1: if data_i != payload, set error_r; advance. No stall on mismatch.
  - 3 DONE: set done_r; addr_r holds. done_o rises the cycle after DONE is fetched.
  - 4 FINISH: identical to DONE. Simulation-only builds may additionally $display a message.
  - 5 CNT_WAIT: if cnt_r==0, advance; else cnt_r <= cnt_r-1 and hold.
  - 6 CNT_LOAD: cnt_r <= payload[counter_width_p-1:0]; advance. Exactly one cycle.
  - 7..15 illegal: set error_r; advance, so the engine does not hang.
- CNT_WAIT timing: after CNT_LOAD N followed directly by CNT_WAIT, the CNT_WAIT occupies N+1 cycles.
- Combinational paths:
  - v_o and ready_and_o are combinational from rom_data_i, en_i and done_r.
  - There is no combinational path from yumi_i or v_i to any output.
- Flag behaviour:
  - done_r and error_r are sticky until reset.
  - error_o is valid independent of done_o.
- en_i deasserted mid-SEND: v_o drops and the instruction is retried when en_i returns. The upstream partner must not assert yumi_i while v_o=0.
- Simultaneity: SEND and RECV never overlap, since there is one opcode per cycle.
- Reset mid-operation: reset aborts any pending SEND/RECV; the trace restarts at address 0.

Test Plan:
- ROM {1:A, 1:B, 3:0}, yumi_i held 1 -> v_o high for 2 cycles with data_o=A then B; then done_o=1, v_o=0; rom_addr_o stays at 2.
- SEND with yumi_i held 0 for 5 cycles, then 1 -> v_o and data_o stable for 6 cycles; exactly one advance.
- ROM {2:0x55, 2:0x66, 3:0}, v_i=1 with data 0x55 then 0x77 -> ready_and_o high for 2 cycles; error_o=1 after the second RECV; done_o=1.
- ROM {6:3, 5:0, 1:X, 3:0} -> v_o first asserts exactly 5 cycles after the CNT_LOAD cycle (1 for load, 4 for CNT_WAIT).
- en_i=0 during a SEND for 3 cycles -> v_o=0 and rom_addr_o unchanged; resumes when en_i=1. Opcode 9 -> error_o=1 and the address advances.
- Assert reset_n_i=0 asynchronously mid-trace -> all outputs 0 immediately; replay restarts from address 0 after release.

Source files
------------

// File: rtl/fsb_trace_replay_engine.sv
// Trace player: steps through {opcode, payload} words from an external ROM and
// replays send/receive/wait transactions, flagging completion and any mismatch.
module fsb_trace_replay_engine #(
    parameter int ring_width_p     = 80,
    parameter int rom_addr_width_p = 20,
    parameter int counter_width_p  = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        en_i,
    input  logic                        v_i,
    input  logic [ring_width_p-1:0]     data_i,
    output logic                        ready_and_o,
    output logic                        v_o,
    output logic [ring_width_p-1:0]     data_o,
    input  logic                        yumi_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [ring_width_p+3:0]     rom_data_i,
    output logic                        done_o,
    output logic                        error_o
);

    localparam logic [3:0] OP_WAIT     = 4'd0;
    localparam logic [3:0] OP_SEND     = 4'd1;
    localparam logic [3:0] OP_RECV     = 4'd2;
    localparam logic [3:0] OP_DONE     = 4'd3;
    localparam logic [3:0] OP_FINISH   = 4'd4;
    localparam logic [3:0] OP_CNT_WAIT = 4'd5;
    localparam logic [3:0] OP_CNT_LOAD = 4'd6;

    logic [rom_addr_width_p-1:0] addr_r, addr_n;
    logic [counter_width_p-1:0]  cnt_r, cnt_n;
    logic                        done_r, done_n;
    logic                        error_r, error_n;

    logic [3:0]                  op;
    logic [ring_width_p-1:0]     payload;
    logic                        active;
    logic [rom_addr_width_p-1:0] addr_inc;

    assign op       = rom_data_i[ring_width_p+3:ring_width_p];
    assign payload  = rom_data_i[ring_width_p-1:0];
    assign active   = en_i & ~done_r;
    assign addr_inc = addr_r + rom_addr_width_p'(1);

    // Handshake outputs are gated by reset so they read 0 while reset is held,
    // even though the ROM word at address 0 is already visible.
    assign v_o         = reset_n_i & active & (op == OP_SEND);
    assign ready_and_o = reset_n_i & active & (op == OP_RECV);
    assign data_o      = payload;
    assign rom_addr_o  = addr_r;
    assign done_o      = done_r;
    assign error_o     = error_r;

    always_comb begin
        addr_n  = addr_r;
        cnt_n   = cnt_r;
        done_n  = done_r;
        error_n = error_r;
        if (active) begin
            case (op)
                OP_WAIT: addr_n = addr_inc;
                OP_SEND: begin
                    if (yumi_i) addr_n = addr_inc;
                end
                OP_RECV: begin
                    if (v_i) begin
                        if (data_i != payload) error_n = 1'b1;
                        addr_n = addr_inc;
                    end
                end
                OP_DONE, OP_FINISH: done_n = 1'b1;
                OP_CNT_WAIT: begin
                    if (cnt_r == '0) addr_n = addr_inc;
                    else             cnt_n  = cnt_r - counter_width_p'(1);
                end
                OP_CNT_LOAD: begin
                    cnt_n  = payload[counter_width_p-1:0];
                    addr_n = addr_inc;
                end
                // Illegal opcodes flag an error but still move on so the trace cannot hang.
                default: begin
                    error_n = 1'b1;
                    addr_n  = addr_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_r  <= '0;
            cnt_r   <= '0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            addr_r  <= addr_n;
            cnt_r   <= cnt_n;
            done_r  <= done_n;
            error_r <= error_n;
        end
    end

endmodule

// File: tb/tb_fsb_trace_replay_engine.sv
// Bench for fsb_trace_replay_engine: directed trace scenarios with literal
// expectations plus randomized traces compared against a behavioural model.
module tb_fsb_trace_replay_engine;

    localparam int RW = 16;
    localparam int AW = 6;
    localparam int CW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          v_in = 1'b0;
    logic [RW-1:0] data_in = '0;
    logic          yumi = 1'b0;
    logic          ready_and, v_out, done, error;
    logic [RW-1:0] data_out;
    logic [AW-1:0] rom_addr;
    logic [RW+3:0] rom_data;
    logic [RW+3:0] rom [DEPTH];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    fsb_trace_replay_engine #(
        .ring_width_p(RW), .rom_addr_width_p(AW), .counter_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .v_i(v_in), .data_i(data_in),
        .ready_and_o(ready_and), .v_o(v_out), .data_o(data_out), .yumi_i(yumi),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data), .done_o(done), .error_o(error)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_addr, m_cnt;
    bit m_done, m_err;

    function automatic int fop(input int a);
        return int'(rom[a % DEPTH][RW+3:RW]);
    endfunction
    function automatic int fpl(input int a);
        return int'(rom[a % DEPTH][RW-1:0]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr <= 0; m_cnt <= 0; m_done <= 0; m_err <= 0;
        end else if (en && !m_done) begin
            case (fop(m_addr))
                0: m_addr <= (m_addr + 1) % DEPTH;
                1: if (yumi) m_addr <= (m_addr + 1) % DEPTH;
                2: if (v_in) begin
                    if (int'(data_in) != fpl(m_addr)) m_err <= 1;
                    m_addr <= (m_addr + 1) % DEPTH;
                end
                3, 4: m_done <= 1;
                5: if (m_cnt == 0) m_addr <= (m_addr + 1) % DEPTH;
                   else m_cnt <= m_cnt - 1;
                6: begin
                    m_cnt <= fpl(m_addr) % (1 << CW);
                    m_addr <= (m_addr + 1) % DEPTH;
                end
                default: begin
                    m_err <= 1;
                    m_addr <= (m_addr + 1) % DEPTH;
                end
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit act;
        act = rst_n && en && !m_done;
        chk("model v_o", v_out, act && fop(m_addr) == 1);
        chk("model ready_and_o", ready_and, act && fop(m_addr) == 2);
        chk("model rom_addr_o", rom_addr, m_addr);
        chk("model done_o", done, m_done);
        chk("model error_o", error, m_err);
        if (v_out) chk("model data_o", data_out, fpl(m_addr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = {4'd3, 16'h0};
    endtask

    // Holds reset for a cycle, releases it with en=1; the next negedge samples cycle 0.
    task automatic start();
        rst_n = 1'b0; en = 1'b0; yumi = 1'b0; v_in = 1'b0; data_in = '0;
        cyc(); cyc();
        rst_n = 1'b1; en = 1'b1;
    endtask

    initial begin
        int k;
        clear_rom();
        cyc();
        @(negedge clk);
        chk("reset v_o", v_out, 0);
        chk("reset ready", ready_and, 0);
        chk("reset addr", rom_addr, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);

        // Two sends with yumi held high, then done.
        clear_rom();
        rom[0] = {4'd1, 16'hAAAA}; rom[1] = {4'd1, 16'hBBBB}; rom[2] = {4'd3, 16'h0};
        start(); yumi = 1'b1;
        @(negedge clk); chk("t1 v0", v_out, 1); chk("t1 d0", data_out, 16'hAAAA);
        cyc(); @(negedge clk); chk("t1 v1", v_out, 1); chk("t1 d1", data_out, 16'hBBBB);
        cyc(); @(negedge clk); chk("t1 v2", v_out, 0); chk("t1 done2", done, 0);
        cyc(); @(negedge clk); chk("t1 done3", done, 1); chk("t1 addr3", rom_addr, 2);
        cyc(); @(negedge clk); chk("t1 addr4", rom_addr, 2); chk("t1 v4", v_out, 0);

        // Send stalled for 5 cycles, consumed on the 6th.
        clear_rom();
        rom[0] = {4'd1, 16'h1234};
        start();
        for (int i = 0; i < 6; i++) begin
            yumi = (i == 5);
            @(negedge clk);
            chk("t2 v", v_out, 1); chk("t2 d", data_out, 16'h1234); chk("t2 addr", rom_addr, 0);
            cyc();
        end
        yumi = 1'b0;
        @(negedge clk); chk("t2 advanced", rom_addr, 1); chk("t2 v after", v_out, 0);

        // Receives: first matches, second mismatches.
        clear_rom();
        rom[0] = {4'd2, 16'h0055}; rom[1] = {4'd2, 16'h0066}; rom[2] = {4'd3, 16'h0};
        start(); v_in = 1'b1; data_in = 16'h0055;
        @(negedge clk); chk("t3 rdy0", ready_and, 1); chk("t3 err0", error, 0);
        cyc(); data_in = 16'h0077;
        @(negedge clk); chk("t3 rdy1", ready_and, 1); chk("t3 err1", error, 0);
        cyc(); v_in = 1'b0;
        @(negedge clk); chk("t3 rdy2", ready_and, 0); chk("t3 err2", error, 1);
        cyc(); @(negedge clk); chk("t3 done", done, 1); chk("t3 err3", error, 1);

        // Counter load 3 then count wait: send appears 5 cycles after the load.
        clear_rom();
        rom[0] = {4'd6, 16'h0003}; rom[1] = {4'd5, 16'h0}; rom[2] = {4'd1, 16'hC0DE};
        start();
        k = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v_out) begin k = i; break; end
            cyc();
        end
        chk("t4 cnt latency", k, 5);
        cyc();

        // en dropped mid-send, then illegal opcode 9.
        clear_rom();
        rom[0] = {4'd1, 16'hD00D}; rom[1] = {4'd9, 16'h0};
        start();
        @(negedge clk); chk("t5 v en1", v_out, 1);
        cyc(); en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t5 v en0", v_out, 0); chk("t5 addr en0", rom_addr, 0);
            cyc();
        end
        en = 1'b1; yumi = 1'b1;
        @(negedge clk); chk("t5 v resume", v_out, 1); chk("t5 d resume", data_out, 16'hD00D);
        cyc(); yumi = 1'b0;
        @(negedge clk); chk("t5 addr op9", rom_addr, 1); chk("t5 err pre", error, 0);
        cyc(); @(negedge clk); chk("t5 err", error, 1); chk("t5 addr post", rom_addr, 2);

        // Asynchronous reset in the middle of a trace.
        clear_rom();
        rom[0] = {4'd9, 16'h0}; rom[1] = {4'd0, 16'h0}; rom[2] = {4'd1, 16'hF00F};
        start();
        cyc(); cyc();
        @(negedge clk); chk("t6 v pre", v_out, 1); chk("t6 err pre", error, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 v rst", v_out, 0); chk("t6 err rst", error, 0);
        chk("t6 addr rst", rom_addr, 0); chk("t6 done rst", done, 0); chk("t6 rdy rst", ready_and, 0);
        cyc(); rst_n = 1'b1;
        @(negedge clk); chk("t6 restart addr", rom_addr, 0);
        cyc(); @(negedge clk); chk("t6 restart err", error, 1);

        // Randomized traces, checked cycle by cycle against the model.
        for (int ep = 0; ep < 6; ep++) begin
            for (int i = 0; i < DEPTH; i++) begin
                int r, op;
                r = $urandom_range(0, 99);
                if      (r < 20) op = 0;
                else if (r < 45) op = 1;
                else if (r < 70) op = 2;
                else if (r < 80) op = 5;
                else if (r < 90) op = 6;
                else if (r < 92) op = 3 + $urandom_range(0, 1);
                else             op = $urandom_range(7, 15);
                rom[i][RW+3:RW] = 4'(op);
                rom[i][RW-1:0]  = (op == 6) ? RW'($urandom_range(0, 7)) : RW'($urandom);
            end
            start();
            for (int c = 0; c < 300; c++) begin
                en   = ($urandom_range(0, 9) < 8);
                yumi = en && !m_done && fop(m_addr) == 1 && ($urandom_range(0, 2) != 0);
                v_in = ($urandom_range(0, 2) != 0);
                data_in = ($urandom_range(0, 3) != 0) ? RW'(fpl(m_addr)) : RW'($urandom);
                cyc();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
